// File: rtl/ysyx_24080006_ifu_if.sv
// Bundle of IFU-facing handshakes: writeback completion, instruction memory, decode.
// master = the IFU, slave = the units and memory around it.
interface ysyx_24080006_ifu_if;
    // writeback completion
    logic        wbu_valid;
    logic        wbu_ready;
    logic        redirect_en;
    logic [31:0] redirect_pc;

    // instruction memory
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        imem_resp_err;

    // decode
    logic        idu_valid;
    logic        idu_ready;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        fetch_fault;

    modport master (
        input  wbu_valid, redirect_en, redirect_pc,
        input  imem_req_ready, imem_resp_valid, imem_resp_data, imem_resp_err,
        input  idu_ready,
        output wbu_ready,
        output imem_req_valid, imem_addr,
        output idu_valid, inst, pc, fetch_fault
    );

    modport slave (
        output wbu_valid, redirect_en, redirect_pc,
        output imem_req_ready, imem_resp_valid, imem_resp_data, imem_resp_err,
        output idu_ready,
        input  wbu_ready,
        input  imem_req_valid, imem_addr,
        input  idu_valid, inst, pc, fetch_fault
    );
endinterface

// File: rtl/ysyx_24080006_ifu.sv
// Multicycle instruction fetch unit: one single-beat fetch per retired instruction.
// Optional performance counters are built when YSYX_IFU_PERF_EN is defined.
module ysyx_24080006_ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic                       clock,
    input  logic                       reset,
    ysyx_24080006_ifu_if.master        bus
`ifdef YSYX_IFU_PERF_EN
    ,
    output logic [31:0]                perf_fetch_cnt,
    output logic [31:0]                perf_stall_cnt
`endif
);

    typedef enum logic [2:0] {
        S_RST,
        S_REQ,
        S_RESP,
        S_HOLD,
        S_WBWAIT
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q,    pc_d;
    logic [31:0] inst_q,  inst_d;
    logic        fault_q, fault_d;

    logic        misaligned;
    logic        req_fire;

    assign misaligned = (pc_q[1:0] != 2'b00);
    // A misaligned PC never reaches the bus; it is turned into a fault locally.
    assign req_fire   = (state_q == S_REQ) && !misaligned && bus.imem_req_ready;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its peers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_RST;
            pc_q    <= RESET_PC;
            inst_q  <= 32'h0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            fault_q <= fault_d;
        end
    end

    always_comb begin
        // NOTE: every variable gets a hold default first, so no path infers a latch.
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        fault_d = fault_q;

        unique case (state_q)
            S_RST: begin
                state_d = S_REQ;
            end
            S_REQ: begin
                if (misaligned) begin
                    inst_d  = 32'h0;
                    fault_d = 1'b1;
                    state_d = S_HOLD;
                end else if (bus.imem_req_ready) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (bus.imem_resp_valid) begin
                    inst_d  = bus.imem_resp_err ? 32'h0 : bus.imem_resp_data;
                    fault_d = bus.imem_resp_err;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (bus.idu_ready) begin
                    state_d = S_WBWAIT;
                end
            end
            S_WBWAIT: begin
                if (bus.wbu_valid) begin
                    // Sequential advance wraps naturally at 2^32.
                    pc_d    = bus.redirect_en ? bus.redirect_pc : pc_q + 32'd4;
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_RST;
            end
        endcase
    end

    // Moore outputs decoded from state.
    assign bus.imem_req_valid = (state_q == S_REQ) && !misaligned;
    assign bus.imem_addr      = pc_q;
    assign bus.idu_valid      = (state_q == S_HOLD);
    assign bus.wbu_ready      = (state_q == S_WBWAIT);
    assign bus.inst           = inst_q;
    assign bus.pc             = pc_q;
    assign bus.fetch_fault    = fault_q;

`ifdef YSYX_IFU_PERF_EN
    logic [31:0] perf_fetch_q;
    logic [31:0] perf_stall_q;
    logic        stall_cycle;

    assign stall_cycle = ((state_q == S_REQ)  && !misaligned && !bus.imem_req_ready) ||
                         ((state_q == S_RESP) && !bus.imem_resp_valid);

    always_ff @(posedge clock) begin
        if (reset) begin
            perf_fetch_q <= 32'h0;
            perf_stall_q <= 32'h0;
        end else begin
            if (req_fire) begin
                perf_fetch_q <= perf_fetch_q + 32'd1;
            end
            if (stall_cycle) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt = perf_fetch_q;
    assign perf_stall_cnt = perf_stall_q;
`else
    logic unused_req_fire;
    assign unused_req_fire = req_fire;
`endif

endmodule

// File: tb/tb_ysyx_24080006_ifu.sv
// Directed self-checking bench for ysyx_24080006_ifu.
module tb_ysyx_24080006_ifu;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    ysyx_24080006_ifu_if bus ();

`ifdef YSYX_IFU_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    ysyx_24080006_ifu #(.RESET_PC(32'h8000_0000)) dut (
        .clock          (clock),
        .reset          (reset),
        .bus            (bus.master)
`ifdef YSYX_IFU_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;
    int req_cnt = 0;
    int idu_cnt = 0;

    // Transfer counters observed on the bus, used as deltas around a test.
    always @(posedge clock) begin
        if (!reset && bus.imem_req_valid && bus.imem_req_ready) req_cnt++;
        if (!reset && bus.idu_valid && bus.idu_ready)           idu_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic accept_idu();
        bus.idu_ready = 1'b1;
        tick();
        bus.idu_ready = 1'b0;
    endtask

    task automatic wb_done(input logic en, input logic [31:0] target);
        bus.wbu_valid   = 1'b1;
        bus.redirect_en = en;
        bus.redirect_pc = target;
        tick();
        bus.wbu_valid   = 1'b0;
        bus.redirect_en = 1'b0;
        bus.redirect_pc = 32'h0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, i0;
`ifdef YSYX_IFU_PERF_EN
        logic [31:0] pf0, ps0;
`endif
        reset               = 1'b1;
        bus.wbu_valid       = 1'b0;
        bus.redirect_en     = 1'b0;
        bus.redirect_pc     = 32'h0;
        bus.imem_req_ready  = 1'b0;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = 32'h0;
        bus.imem_resp_err   = 1'b0;
        bus.idu_ready       = 1'b0;
        repeat (3) tick();

        check("rst_pc",        bus.pc,                 32'h8000_0000);
        check("rst_inst",      bus.inst,               32'h0);
        check("rst_fault",     {31'h0, bus.fetch_fault},    32'h0);
        check("rst_req_valid", {31'h0, bus.imem_req_valid}, 32'h0);
        check("rst_idu_valid", {31'h0, bus.idu_valid},      32'h0);
        check("rst_wbu_ready", {31'h0, bus.wbu_ready},      32'h0);
`ifdef YSYX_IFU_PERF_EN
        check("rst_perf_fetch", perf_fetch_cnt, 32'h0);
        check("rst_perf_stall", perf_stall_cnt, 32'h0);
`endif

        // Zero-wait memory, first fetch after reset release.
        bus.imem_req_ready  = 1'b1;
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_data  = 32'h0000_0413;
        reset = 1'b0;
        check("cyc1_no_req", {31'h0, bus.imem_req_valid}, 32'h0);
        tick();
        check("cyc2_req_valid", {31'h0, bus.imem_req_valid}, 32'h1);
        check("cyc2_addr",      bus.imem_addr, 32'h8000_0000);
        tick();
        check("resp_req_low",   {31'h0, bus.imem_req_valid}, 32'h0);
        tick();
        check("first_idu_valid", {31'h0, bus.idu_valid}, 32'h1);
        check("first_inst",      bus.inst, 32'h0000_0413);
        check("first_pc",        bus.pc,   32'h8000_0000);
        check("first_fault",     {31'h0, bus.fetch_fault}, 32'h0);
        check("hold_wbu_ready",  {31'h0, bus.wbu_ready}, 32'h0);
        bus.wbu_valid = 1'b1;          // ignored outside WBWAIT
        tick();
        bus.wbu_valid = 1'b0;
        check("hold_stays",      {31'h0, bus.idu_valid}, 32'h1);
        check("hold_wbu_ready2", {31'h0, bus.wbu_ready}, 32'h0);
        accept_idu();
        check("wbwait_ready", {31'h0, bus.wbu_ready}, 32'h1);
        check("wbwait_idu",   {31'h0, bus.idu_valid}, 32'h0);

        // Sequential advance.
        bus.imem_resp_data = 32'h00a0_0093;
        wb_done(1'b0, 32'h1234_5678);
        check("seq_req_valid", {31'h0, bus.imem_req_valid}, 32'h1);
        check("seq_addr",      bus.imem_addr, 32'h8000_0004);
        tick();
        tick();
        check("seq_inst", bus.inst, 32'h00a0_0093);
        check("seq_pc",   bus.pc,   32'h8000_0004);

        // Redirect, then misaligned redirect.
        accept_idu();
        bus.imem_resp_data = 32'h0010_0113;
        wb_done(1'b1, 32'h8000_0100);
        check("redir_addr", bus.imem_addr, 32'h8000_0100);
        check("redir_req",  {31'h0, bus.imem_req_valid}, 32'h1);
        tick();
        tick();
        check("redir_inst", bus.inst, 32'h0010_0113);
        accept_idu();
        r0 = req_cnt;
        wb_done(1'b1, 32'h8000_0102);
        check("mis_no_req", {31'h0, bus.imem_req_valid}, 32'h0);
        tick();
        check("mis_idu_valid", {31'h0, bus.idu_valid}, 32'h1);
        check("mis_fault",     {31'h0, bus.fetch_fault}, 32'h1);
        check("mis_inst",      bus.inst, 32'h0);
        check("mis_pc",        bus.pc,   32'h8000_0102);
        check("mis_req_cnt",   req_cnt - r0, 32'h0);

        // Stalls on request, response and decode.
        accept_idu();
        bus.imem_req_ready  = 1'b0;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = 32'h0020_0193;
        r0 = req_cnt;
        i0 = idu_cnt;
`ifdef YSYX_IFU_PERF_EN
        pf0 = perf_fetch_cnt;
        ps0 = perf_stall_cnt;
`endif
        wb_done(1'b1, 32'h8000_0200);
        for (int k = 0; k < 3; k++) begin
            check("stall_req_valid", {31'h0, bus.imem_req_valid}, 32'h1);
            check("stall_req_addr",  bus.imem_addr, 32'h8000_0200);
            tick();
        end
        bus.imem_req_ready = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            check("stall_resp_noreq", {31'h0, bus.imem_req_valid}, 32'h0);
            check("stall_resp_addr",  bus.imem_addr, 32'h8000_0200);
            tick();
        end
        bus.imem_resp_valid = 1'b1;
        tick();
        bus.imem_resp_data = 32'hFFFF_FFFF;   // must not disturb the held word
        for (int k = 0; k < 2; k++) begin
            check("stall_hold_inst", bus.inst, 32'h0020_0193);
            check("stall_hold_pc",   bus.pc,   32'h8000_0200);
            tick();
        end
        check("stall_hold_valid", {31'h0, bus.idu_valid}, 32'h1);
        accept_idu();
        check("stall_one_req", req_cnt - r0, 32'h1);
        check("stall_one_idu", idu_cnt - i0, 32'h1);
`ifdef YSYX_IFU_PERF_EN
        check("perf_stall_delta", perf_stall_cnt - ps0, 32'd7);
        check("perf_fetch_delta", perf_fetch_cnt - pf0, 32'd1);
`endif

        // Bus error, then wrap of the sequential PC.
        bus.imem_resp_err  = 1'b1;
        bus.imem_resp_data = 32'hDEAD_BEEF;
        wb_done(1'b1, 32'hFFFF_FFFC);
        check("err_addr", bus.imem_addr, 32'hFFFF_FFFC);
        tick();
        tick();
        check("err_fault", {31'h0, bus.fetch_fault}, 32'h1);
        check("err_inst",  bus.inst, 32'h0);
        check("err_pc",    bus.pc,   32'hFFFF_FFFC);
        bus.imem_resp_err = 1'b0;
        accept_idu();
        wb_done(1'b0, 32'h0);
        check("wrap_addr", bus.imem_addr, 32'h0);
        check("wrap_req",  {31'h0, bus.imem_req_valid}, 32'h1);

        // Reset while a response is outstanding.
        bus.imem_resp_valid = 1'b0;
        tick();
        check("prerst_in_resp", {31'h0, bus.imem_req_valid}, 32'h0);
        reset = 1'b1;
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_data  = 32'h1234_5678;
        tick();
        tick();
        reset = 1'b0;
        bus.imem_resp_valid = 1'b0;
        check("mrst_pc",    bus.pc,   32'h8000_0000);
        check("mrst_inst",  bus.inst, 32'h0);
        check("mrst_fault", {31'h0, bus.fetch_fault}, 32'h0);
        check("mrst_idu",   {31'h0, bus.idu_valid},   32'h0);
`ifdef YSYX_IFU_PERF_EN
        check("mrst_perf_fetch", perf_fetch_cnt, 32'h0);
        check("mrst_perf_stall", perf_stall_cnt, 32'h0);
`endif
        tick();
        check("mrst_addr", bus.imem_addr, 32'h8000_0000);
        check("mrst_req",  {31'h0, bus.imem_req_valid}, 32'h1);
        tick();
        check("mrst_inst_wait", bus.inst, 32'h0);
        check("mrst_idu_wait",  {31'h0, bus.idu_valid}, 32'h0);
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_data  = 32'h0010_0073;
        tick();
        check("mrst_new_inst",  bus.inst, 32'h0010_0073);
        check("mrst_new_valid", {31'h0, bus.idu_valid}, 32'h1);
        check("mrst_new_fault", {31'h0, bus.fetch_fault}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ysyx_24080006_ifu.md
# ysyx_24080006_ifu

Instruction fetch unit for the riscv32e multicycle core: the receiving end of the writeback unit's completion handshake. After reset it fetches the first instruction at RESET_PC. After that, it waits for the writeback unit to signal completion, selects the next PC (sequential or redirected), and issues a single-beat fetch on the instruction memory port. It then holds the fetched instruction for the decode unit under valid/ready.

## Interface
- RESET_PC, 32'h8000_0000, PC loaded on reset; first fetch address.
- clock  in  1  core clock; all state on rising edge.
- reset  in  1  synchronous, active-high.
- wbu_valid  in  1  writeback done for current instruction; held until accepted.
- wbu_ready  out  1  IFU can accept writeback completion.
- redirect_en  in  1  qualified by wbu handshake; 1 = taken branch/jump/trap.
- redirect_pc  in  32  target PC when redirect_en=1.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_addr  out  32  fetch address; equals pc while imem_req_valid=1.
- imem_resp_valid  in  1  response beat; always accepted, no backpressure.
- imem_resp_data  in  32  instruction word.
- imem_resp_err  in  1  bus error on this response.
- idu_valid  out  1  inst/pc/fetch_fault valid for decode.
- idu_ready  in  1  decode accepts.
- inst  out  32  fetched instruction.
- pc  out  32  address of inst.
- fetch_fault  out  1  inst is invalid (misaligned PC or bus error).

## Operation
- FSM states: RST, REQ, RESP, HOLD, WBWAIT. All outputs are registered or Moore-decoded from state.
- RST → REQ unconditionally after one cycle. The first fetch does not wait for the writeback unit.
- REQ: imem_req_valid=1, imem_addr=pc. On imem_req_valid&&imem_req_ready → RESP.
- REQ with pc[1:0]!=0: no request is issued. The block latches inst=0 and fetch_fault=1, then goes → HOLD.
- RESP: on imem_resp_valid, latch inst=imem_resp_data and fetch_fault=imem_resp_err, then → HOLD. On a bus error, inst=0.
- HOLD: idu_valid=1. inst, pc and fetch_fault stay stable until idu_valid&&idu_ready, then → WBWAIT.
- WBWAIT: wbu_ready=1. On wbu_valid&&wbu_ready, pc <= redirect_en ? redirect_pc : pc+4, then → REQ.
- pc+4 is modulo 2^32: 32'hFFFF_FFFC wraps to 0.
- The following inputs are ignored in states other than the one named:
  - wbu_valid, redirect_en and redirect_pc outside WBWAIT.
  - imem_resp_valid outside RESP.
  - idu_ready outside HOLD.

## Timing
- Reset values: pc=RESET_PC, inst=0, fetch_fault=0, imem_req_valid=0, idu_valid=0, wbu_ready=0, state=RST.
- The cycle after reset deasserts is RST. imem_req_valid rises one cycle later (second cycle after reset release).
- wbu handshake edge → imem_req_valid=1 with the new imem_addr in the next cycle (1-cycle latency).
- Request accepted at edge N → a response is accepted from cycle N+1 onward. Zero-wait memory gives idu_valid=1 one cycle after the response edge.
- Best-case loop, from wbu handshake to idu_valid: 3 cycles (REQ, RESP, HOLD).
- Only one request is outstanding at a time. imem_req_valid is never asserted again until HOLD and WBWAIT have completed.
- Reset mid-operation returns to RST, discards any outstanding response, and restores pc=RESET_PC. The memory is reset by the same reset.

## Configuration
- YSYX_IFU_PERF_EN defined: adds two 32-bit output ports.
  - perf_fetch_cnt: increments on every accepted fetch request.
  - perf_stall_cnt: increments on every cycle in REQ with imem_req_ready=0, or in RESP with imem_resp_valid=0.
  - Both counters reset to 0 and wrap modulo 2^32.
- Not defined: these ports and counters do not exist. Fetch behaviour is identical either way.

## Test plan
- Reset release with zero-wait memory returning 32'h0000_0413:
  - imem_req_valid=1 with imem_addr=32'h8000_0000 on the 2nd cycle after reset release.
  - idu_valid=1 with inst=32'h0000_0413 and pc=32'h8000_0000.
- IDU accepts, then wbu_valid=1 with redirect_en=0 → next imem_addr=32'h8000_0004, one cycle after the wbu handshake. wbu_ready=0 before idu acceptance.
- wbu_valid=1, redirect_en=1, redirect_pc=32'h8000_0100 → imem_addr=32'h8000_0100. Then redirect_pc=32'h8000_0102 → no imem request; idu_valid with fetch_fault=1, inst=0, pc=32'h8000_0102.
- imem_req_ready low for 3 cycles, response delayed 4 cycles, idu_ready low for 2 cycles → imem_addr, inst and pc stable throughout; exactly one request and one IDU transfer. With YSYX_IFU_PERF_EN: perf_stall_cnt=7, perf_fetch_cnt+=1.
- Response with imem_resp_err=1 → fetch_fault=1, inst=0. Also pc=32'hFFFF_FFFC with sequential advance → next imem_addr=0.
- Reset asserted in RESP, with the response arriving during reset → ignored; the next fetch is at 32'h8000_0000 and inst=0 until the new response.
